vectoring_arbiter: RTL and testbench

- Shares one pipelined `vectoring` datapath instance (REG_EN=1) among NREQ requesters using valid/ready handshakes.
- Arbitration is round-robin. The block tracks in-flight operations with a tag pipeline matched to the datapath latency.
- Results are buffered in a result FIFO, so the downstream consumer may apply backpressure without losing data.
- Sits between the polar-conversion clients (magnitude/phase users) and the single CORDIC vectoring core.

---
 rtl/vectoring_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_vectoring_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vectoring_arbiter.sv
// vectoring_arbiter: shares one pipelined CORDIC vectoring datapath among
// NREQ requesters. Round-robin grant, credit-limited issue, a tag pipeline
// matched to the datapath latency and a first-word-fall-through result FIFO.
// Optional per-requester handshake counters: define VECTORING_ARB_STATS_EN.
module vectoring_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int OW    = 16,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [NREQ*DW-1:0]        req_x_i,
    input  logic [NREQ*DW-1:0]        req_y_i,
    output logic [DW-1:0]             dp_x_o,
    output logic [DW-1:0]             dp_y_o,
    output logic                      dp_valid_o,
    input  logic [OW-1:0]             dp_r_i,
    input  logic [AW-1:0]             dp_angle_i,
    input  logic [1:0]                dp_quadrant_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [$clog2(NREQ)-1:0]   res_id_o,
    output logic [OW-1:0]             res_r_o,
    output logic [AW-1:0]             res_angle_o,
    output logic [1:0]                res_quadrant_o,
    output logic                      busy_o,
    input  logic [$clog2(NREQ)-1:0]   stat_sel_i,
    output logic [15:0]               stat_cnt_o
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = IW + OW + AW + 2;

    logic [IW-1:0]  rr_ptr_q;
    logic [LAT-1:0] tag_vld_q;
    logic [IW-1:0]  tag_id_q [LAT];
    logic [EW-1:0]  fifo_mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  fifo_cnt_q;

    logic [CW-1:0]  inflight;
    logic [CW:0]    occupancy;
    logic           issue_ok;
    logic           gnt_found;
    logic [IW-1:0]  gnt_idx;
    int             cand;
    logic           hs;
    logic           push;
    logic           pop;
    logic           fifo_empty;
    logic           fifo_full;
    logic [EW-1:0]  push_data;
    logic [EW-1:0]  head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Count tags currently travelling through the datapath.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(tag_vld_q[i]);
        end
    end

    // Issue only while every in-flight result is guaranteed a FIFO slot;
    // reset also blocks issue so nothing is accepted while it is held.
    assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, inflight};
    assign issue_ok  = rst_ni && (occupancy < (CW+1)'(DEPTH));

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NREQ;
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(cand);
            end
        end
    end

    assign hs          = gnt_found && issue_ok;
    assign req_ready_o = hs ? (NREQ'(1) << gnt_idx) : '0;
    assign dp_valid_o  = hs;
    assign dp_x_o      = hs ? req_x_i[gnt_idx*DW +: DW] : '0;
    assign dp_y_o      = hs ? req_y_i[gnt_idx*DW +: DW] : '0;

    // Round-robin pointer and tag pipeline follow each accepted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q  <= IW'(NREQ - 1);
            tag_vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            if (hs) begin
                rr_ptr_q <= gnt_idx;
            end
            tag_vld_q[0] <= hs;
            tag_id_q[0]  <= gnt_idx;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign push       = tag_vld_q[LAT-1];
    assign push_data  = {tag_id_q[LAT-1], dp_r_i, dp_angle_i, dp_quadrant_i};
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == CW'(DEPTH));
    assign pop        = !fifo_empty && res_ready_i;

    // FIFO storage; contents are only visible through the head when non-empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    assign head        = fifo_mem_q[rd_ptr_q];
    assign res_valid_o = !fifo_empty;
    assign {res_id_o, res_r_o, res_angle_o, res_quadrant_o} = fifo_empty ? '0 : head;
    assign busy_o      = (inflight != '0) || !fifo_empty;

    // The credit rule makes a write into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));

`ifdef VECTORING_ARB_STATS_EN
    logic [15:0] stat_cnt_q [NREQ];

    // Saturating handshake counter per requester.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_cnt_q[i] <= '0;
            end
        end else if (hs && (stat_cnt_q[gnt_idx] != 16'hFFFF)) begin
            stat_cnt_q[gnt_idx] <= stat_cnt_q[gnt_idx] + 16'd1;
        end
    end

    assign stat_cnt_o = (int'(stat_sel_i) < NREQ) ? stat_cnt_q[stat_sel_i] : '0;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel_i;
    assign stat_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_vectoring_arbiter.sv
// Directed and scoreboarded bench for vectoring_arbiter (NREQ=4, LAT=1, DEPTH=4).
// The datapath is a one-register stand-in: r=|x|+|y|, angle=|y|, quadrant={y<0,x<0}.
module tb_vectoring_arbiter;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [3:0]    req_valid_i;
    logic [3:0]    req_ready_o;
    logic [63:0]   req_x_i;
    logic [63:0]   req_y_i;
    logic [15:0]   dp_x_o;
    logic [15:0]   dp_y_o;
    logic          dp_valid_o;
    logic [15:0]   dp_r_i;
    logic [15:0]   dp_angle_i;
    logic [1:0]    dp_quadrant_i;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [1:0]    res_id_o;
    logic [15:0]   res_r_o;
    logic [15:0]   res_angle_o;
    logic [1:0]    res_quadrant_o;
    logic          busy_o;
    logic [1:0]    stat_sel_i;
    logic [15:0]   stat_cnt_o;

    logic [15:0]   rx [4];
    logic [15:0]   ry [4];
    logic [33:0]   dp_q;
    logic [35:0]   exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;

    vectoring_arbiter dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_x_i        (req_x_i),
        .req_y_i        (req_y_i),
        .dp_x_o         (dp_x_o),
        .dp_y_o         (dp_y_o),
        .dp_valid_o     (dp_valid_o),
        .dp_r_i         (dp_r_i),
        .dp_angle_i     (dp_angle_i),
        .dp_quadrant_i  (dp_quadrant_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_id_o       (res_id_o),
        .res_r_o        (res_r_o),
        .res_angle_o    (res_angle_o),
        .res_quadrant_o (res_quadrant_o),
        .busy_o         (busy_o),
        .stat_sel_i     (stat_sel_i),
        .stat_cnt_o     (stat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [33:0] dp_model(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] ax;
        logic [15:0] ay;
        ax = x[15] ? -x : x;
        ay = y[15] ? -y : y;
        return {ax + ay, ay, y[15], x[15]};
    endfunction

    function automatic logic [35:0] exp_res(input int k);
        logic [1:0] id;
        id = 2'(k);
        return {id, dp_model(rx[k], ry[k])};
    endfunction

    // One-cycle datapath stand-in.
    always @(posedge clk_i) dp_q <= dp_model(dp_x_o, dp_y_o);
    assign {dp_r_i, dp_angle_i, dp_quadrant_i} = dp_q;

    // Pack per-requester stimulus onto the flat buses.
    always_comb begin
        req_x_i = '0;
        req_y_i = '0;
        for (int k = 0; k < 4; k++) begin
            req_x_i[k*16 +: 16] = rx[k];
            req_y_i[k*16 +: 16] = ry[k];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [35:0] res_pack();
        return {res_id_o, res_r_o, res_angle_o, res_quadrant_o};
    endfunction

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b0;
        req_valid_i = '0;
        #3;
        rst_ni      = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard step at the negedge: log accepted requests, compare popped results.
    task automatic monitor(output logic [3:0] acc);
        acc = req_valid_i & req_ready_o;
        check_eq("ready_onehot0", 64'($onehot0(req_ready_o)), 64'd1);
        for (int k = 0; k < 4; k++) begin
            if (acc[k]) exp_q.push_back(exp_res(k));
        end
        if (res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
                check_eq("res_unexpected", 64'(res_valid_o), 64'd0);
            end else begin
                check_eq("sb_result", 64'(res_pack()), 64'(exp_q.pop_front()));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] acc;
        int         hs_cnt;
        int         drain_ids [5];

        rst_ni      = 1'b0;
        req_valid_i = '0;
        res_ready_i = 1'b1;
        stat_sel_i  = '0;
        for (int k = 0; k < 4; k++) begin
            rx[k] = '0;
            ry[k] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_res_valid", 64'(res_valid_o), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready_o), 64'd0);
        check_eq("rst_dp_valid", 64'(dp_valid_o), 64'd0);
        check_eq("rst_stat", 64'(stat_cnt_o), 64'd0);
        check_eq("rst_res_r", 64'(res_r_o), 64'd0);
        do_reset();

        // Single request from requester 0
        rx[0] = 16'd1000;
        ry[0] = 16'd0;
        req_valid_i = 4'b0001;
        @(negedge clk_i);
        check_eq("single_ready", 64'(req_ready_o), 64'h1);
        check_eq("single_dp_valid", 64'(dp_valid_o), 64'd1);
        check_eq("single_dp_x", 64'(dp_x_o), 64'd1000);
        @(posedge clk_i);
        #1;
        req_valid_i = '0;
        @(negedge clk_i);
        check_eq("single_inflight_valid", 64'(res_valid_o), 64'd0);
        check_eq("single_inflight_busy", 64'(busy_o), 64'd1);
        check_eq("single_dp_idle_x", 64'(dp_x_o), 64'd0);
        @(negedge clk_i);
        check_eq("single_res_valid", 64'(res_valid_o), 64'd1);
        check_eq("single_res", 64'(res_pack()), {28'd0, 2'd0, 16'd1000, 16'd0, 2'd0});
        @(negedge clk_i);
        check_eq("single_done_valid", 64'(res_valid_o), 64'd0);
        check_eq("single_done_busy", 64'(busy_o), 64'd0);

        // All four requesters continuously valid
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rx[k] = 16'(100 * (k + 1));
            ry[k] = 16'(-(10 * k));
        end
        req_valid_i = 4'hF;
        res_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            check_eq("rr_grant", 64'(req_ready_o), 64'(4'b0001 << (i % 4)));
            if (i >= 2) begin
                check_eq("rr_res_valid", 64'(res_valid_o), 64'd1);
                check_eq("rr_res", 64'(res_pack()), 64'(exp_res((i - 2) % 4)));
            end
        end
        @(posedge clk_i);
        #1;
        req_valid_i = '0;
        repeat (4) @(posedge clk_i);

        // Consumer stalled: credit limit, then drain in order
        do_reset();
        res_ready_i = 1'b0;
        req_valid_i = 4'hF;
        hs_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (req_ready_o != '0) hs_cnt++;
            if (i < 4) check_eq("bp_grant", 64'(req_ready_o), 64'(4'b0001 << i));
        end
        check_eq("bp_handshakes", 64'(hs_cnt), 64'd4);
        check_eq("bp_ready_blocked", 64'(req_ready_o), 64'd0);
        check_eq("bp_res_valid", 64'(res_valid_o), 64'd1);
        check_eq("bp_busy", 64'(busy_o), 64'd1);
        @(posedge clk_i);
        #1;
        res_ready_i = 1'b1;
        drain_ids = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_eq("bp_drain_valid", 64'(res_valid_o), 64'd1);
            check_eq("bp_drain_res", 64'(res_pack()), 64'(exp_res(drain_ids[i])));
            if (i == 0) check_eq("bp_resume_c0", 64'(req_ready_o), 64'h0);
            if (i == 1) check_eq("bp_resume_c1", 64'(req_ready_o), 64'h1);
            if (i == 2) check_eq("bp_resume_c2", 64'(req_ready_o), 64'h2);
        end
        @(posedge clk_i);
        #1;
        req_valid_i = '0;
        repeat (8) @(posedge clk_i);

        // Random traffic against the scoreboard
        do_reset();
        exp_q.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk_i);
            monitor(acc);
            @(posedge clk_i);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (!req_valid_i[k] || acc[k]) begin
                    req_valid_i[k] = 1'($urandom_range(0, 1));
                    rx[k] = 16'($urandom);
                    ry[k] = 16'($urandom);
                end
            end
            res_ready_i = ($urandom_range(0, 9) < 6);
        end
        req_valid_i = '0;
        res_ready_i = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk_i);
            monitor(acc);
        end
        check_eq("sb_leftover", 64'(exp_q.size()), 64'd0);
        check_eq("sb_idle_busy", 64'(busy_o), 64'd0);

        // Reset with one op in flight and two results queued
        do_reset();
        res_ready_i = 1'b0;
        rx[0] = 16'd500;
        ry[0] = 16'd0;
        req_valid_i = 4'b0001;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("mid_pre_valid", 64'(res_valid_o), 64'd1);
        check_eq("mid_pre_busy", 64'(busy_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(res_valid_o), 64'd0);
        check_eq("mid_rst_busy", 64'(busy_o), 64'd0);
        check_eq("mid_rst_ready", 64'(req_ready_o), 64'd0);
        check_eq("mid_rst_dp_valid", 64'(dp_valid_o), 64'd0);
        req_valid_i = '0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        res_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_eq("mid_post_valid", 64'(res_valid_o), 64'd0);
            check_eq("mid_post_busy", 64'(busy_o), 64'd0);
        end

        // Handshake statistics
        do_reset();
        rx[2] = 16'd7;
        ry[2] = 16'd3;
        req_valid_i = 4'b0100;
        repeat (5) @(posedge clk_i);
        #1;
        req_valid_i = '0;
        stat_sel_i = 2'd2;
        #1;
`ifdef VECTORING_ARB_STATS_EN
        check_eq("stat_req2", 64'(stat_cnt_o), 64'd5);
`else
        check_eq("stat_req2", 64'(stat_cnt_o), 64'd0);
`endif
        stat_sel_i = 2'd0;
        #1;
        check_eq("stat_req0", 64'(stat_cnt_o), 64'd0);
        repeat (4) @(posedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
